fft_input_framer: RTL
=====================

Name: fft_input_framer

Overview:
- Upstream neighbour of the 16-point pipelined FFT core.
- Accepts a serial stream of complex 16-bit samples over a valid/ready handshake.
- Assembles the samples into N-sample frames in a two-bank ping-pong buffer.
- Presents each complete frame in parallel, natural order, on flat buses that feed the FFT's real and imaginary input vectors.

Parameters:
- N, 16: samples per frame; power of 2, at least 4; must match the FFT size.
- W, 16: sample width per real/imaginary component, two's complement.
- PRESCALE_SHIFT, 4: arithmetic right shift applied when FFT_PRESCALE_EN is defined; legal range 0..W-1.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- s_valid  in  1  input sample valid.
- s_ready  out  1  framer can accept a sample.
- s_first  in  1  marks the accepted sample as frame index 0 (resync).
- s_re  in  W  input sample real part.
- s_im  in  W  input sample imaginary part.
- m_valid  out  1  complete frame available.
- m_ready  in  1  consumer takes the frame.
- m_re  out  N*W  frame real parts; sample k at bits [k*W +: W].
- m_im  out  N*W  frame imaginary parts; same packing.
- frame_cnt  out  16  frames delivered; wraps modulo 2^16.
- sync_err  out  1  sticky: a resync discarded a partial frame.

Behaviour:
- Reset (async assert, sync release): wr_bank=0, rd_bank=0, wr_idx=0, full[1:0]=0, frame_cnt=0, sync_err=0, both banks' contents cleared to 0.
  - Outputs in reset: s_ready=1, m_valid=0, m_re=0, m_im=0.
  - Reset mid-frame discards all partial and complete frames.
- Accept: a sample is accepted when s_valid && s_ready.
  - s_ready = !full[wr_bank]; combinational, no dependence on s_valid.
- Write: an accepted sample is stored in bank[wr_bank] at index wr_idx, then wr_idx increments.
  - When wr_idx == N-1 at acceptance: full[wr_bank] is set, wr_bank toggles, and wr_idx wraps to 0, all on the same edge.
- Resync: if s_first is set on an accepted sample and wr_idx != 0:
  - The partial frame is discarded and the sample is written at index 0.
  - wr_idx becomes 1 and sync_err is set.
  - s_first with wr_idx == 0 is a no-op flag.
  - s_first is ignored when the sample is not accepted.
- Output side:
  - m_valid = full[rd_bank].
  - m_re/m_im are driven combinationally from the bank[rd_bank] registers.
  - The bus is stable while m_valid=1 and m_ready=0.
- Release: on m_valid && m_ready, full[rd_bank] is cleared, rd_bank toggles, and frame_cnt increments. The freed bank is writable the next cycle.
- Simultaneous completion of a write frame and release of the other bank in one cycle is legal; both updates take effect.
- Both banks full: s_ready=0 and input stalls; no sample is lost or overwritten.
- Throughput:
  - Sustained 1 sample/cycle with m_ready held high.
  - First m_valid rises the cycle after the N-th accepted sample, so latency is 1 cycle from last sample to frame valid.
- Timing: no combinational path from s_valid to s_ready or from m_ready to m_valid.

Optional Feature:
- Macro: FFT_PRESCALE_EN.
- Defined: each accepted component is arithmetic-shifted right by PRESCALE_SHIFT (sign-extended, truncating toward -inf) before storage. This prevents growth overflow in the unscaled FFT butterflies.
- Undefined: samples are stored unmodified.
- Handshake, latency and all other behaviour are identical in both builds.

Test Plan:
- Reset, then stream 16 samples s_re=k, s_im=-k (k=0..15) with m_ready=1 -> m_valid high 1 cycle after the 16th accept; m_re lane k=k, m_im lane k=-k; frame_cnt=1.
- m_ready=0 with 40 samples offered continuously -> 32 accepted, s_ready drops after the 32nd accept; m_valid stays 1 with frame 0 stable.
  - Then m_ready=1 for one cycle -> frame_cnt=1, s_ready=1 the next cycle, and the second frame appears unchanged.
- Continuous 64-sample stream with m_ready=1 -> 4 frames; s_ready never deasserts; frame_cnt=4.
- Accept 5 samples, then a sample 0x7FFF with s_first=1 -> sync_err=1.
  - 15 more samples complete the frame; lane 0 = 0x7FFF, and none of the 5 discarded values appear.
- Assert rst for one cycle after 10 accepted samples -> immediately m_valid=0, s_ready=1, frame_cnt=0, sync_err=0.
  - The next 16 samples form a clean frame.
- With FFT_PRESCALE_EN and PRESCALE_SHIFT=4: inputs 0x7FF0, 0x8000, -1 -> stored 0x07FF, 0xF800, 0xFFFF.

Source files
------------

// File: rtl/fft_input_framer.sv
// Serial-to-parallel framer feeding the 16-point FFT: collects complex samples
// into a ping-pong pair of N-sample banks. Optional input prescaling: FFT_PRESCALE_EN.
module fft_input_framer #(
    parameter int N              = 16,
    parameter int W              = 16,
    parameter int PRESCALE_SHIFT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             s_first,
    input  logic [W-1:0]     s_re,
    input  logic [W-1:0]     s_im,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [N*W-1:0]   m_re,
    output logic [N*W-1:0]   m_im,
    output logic [15:0]      frame_cnt,
    output logic             sync_err
);

    localparam int IW = $clog2(N);
`ifdef FFT_PRESCALE_EN
    localparam bit PRESCALE_EN = 1'b1;
`else
    localparam bit PRESCALE_EN = 1'b0;
`endif
    localparam int APPLIED_SHIFT = PRESCALE_EN ? PRESCALE_SHIFT : 0;

    // Arithmetic shift floors toward -inf, keeping butterfly growth in range.
    function automatic logic signed [W-1:0] prescale(input logic signed [W-1:0] x);
        return x >>> APPLIED_SHIFT;
    endfunction

    logic            wr_bank_q, wr_bank_d;
    logic            rd_bank_q, rd_bank_d;
    logic [IW-1:0]   wr_idx_q, wr_idx_d;
    logic [1:0]      full_q, full_d;
    logic [15:0]     frame_cnt_q, frame_cnt_d;
    logic            sync_err_q, sync_err_d;
    logic [N*W-1:0]  re_q [2];
    logic [N*W-1:0]  im_q [2];

    logic            accept;
    logic            rel;
    logic            resync;
    logic [IW-1:0]   wr_lane;
    int              lane_base;
    logic signed [W-1:0] re_scaled;
    logic signed [W-1:0] im_scaled;

    assign s_ready   = !full_q[wr_bank_q];
    assign m_valid   = full_q[rd_bank_q];
    assign accept    = s_valid && s_ready;
    assign rel       = m_valid && m_ready;
    assign resync    = accept && s_first && (wr_idx_q != '0);
    assign wr_lane   = resync ? '0 : wr_idx_q;
    assign lane_base = int'(wr_lane) * W;
    assign re_scaled = prescale(s_re);
    assign im_scaled = prescale(s_im);

    assign m_re      = re_q[rd_bank_q];
    assign m_im      = im_q[rd_bank_q];
    assign frame_cnt = frame_cnt_q;
    assign sync_err  = sync_err_q;

    // Release and write completion always target different banks, so both may land together.
    always_comb begin
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        wr_idx_d    = wr_idx_q;
        full_d      = full_q;
        frame_cnt_d = frame_cnt_q;
        sync_err_d  = sync_err_q;
        if (rel) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
            frame_cnt_d       = frame_cnt_q + 16'd1;
        end
        if (accept) begin
            if (resync) begin
                wr_idx_d   = IW'(1);
                sync_err_d = 1'b1;
            end else if (wr_idx_q == IW'(N-1)) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
                wr_idx_d          = '0;
            end else begin
                wr_idx_d = wr_idx_q + IW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            wr_idx_q    <= '0;
            full_q      <= '0;
            frame_cnt_q <= '0;
            sync_err_q  <= 1'b0;
        end else begin
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            wr_idx_q    <= wr_idx_d;
            full_q      <= full_d;
            frame_cnt_q <= frame_cnt_d;
            sync_err_q  <= sync_err_d;
        end
    end

    // Banks are cleared on reset so the output bus reads zero until a frame lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            re_q[0] <= '0;
            re_q[1] <= '0;
            im_q[0] <= '0;
            im_q[1] <= '0;
        end else if (accept) begin
            re_q[wr_bank_q][lane_base +: W] <= re_scaled;
            im_q[wr_bank_q][lane_base +: W] <= im_scaled;
        end
    end

endmodule
